stream_sink_checker: RTL and testbench

- Downstream consumer of the spam-filter core's 512-bit result FIFO (dout / empty_n / read, ap_fifo style); replaces the free-running sink plus handshake counters in bench and on-board harness.
- Drains a programmed number of beats, counts them and the stalls, and folds the data into a 64-bit signature. Flags done or timeout for the host or bench.

---
 rtl/sink_pkg.sv | 46 ++++
 rtl/stream_sink_lfsr.sv | 46 ++++
 rtl/stream_sink_checker.sv | 145 ++++++++++++++
 tb/tb_stream_sink_checker.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/sink_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sink_pkg
// Description : Shared types and helpers for the stream sink checker:
//               run-state encoding, lane width, signature helpers and the
//               throttle LFSR defaults.
// Revision    : 1.0 - initial release
// ============================================================================
package sink_pkg;

   // Run-state encoding shared by the checker and its bench.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2,
      TOUT = 2'd3
   } state_e;

   localparam int unsigned LANE_W     = 64;
   // Widest beat the fold helper accepts; narrower beats are zero-extended.
   localparam int unsigned MAX_DATA_W = 2048;

   // Fibonacci taps 16,14,13,11 expressed as a mask over bits [15:0].
   localparam logic [15:0] SINK_LFSR_TAPS = 16'hB400;
   localparam logic [15:0] SINK_LFSR_SEED = 16'hACE1;

   // XOR of the first `lanes` 64-bit lanes of a beat.
   function automatic logic [LANE_W-1:0] fold64(input logic [MAX_DATA_W-1:0] d,
                                                input int unsigned lanes);
      logic [LANE_W-1:0] acc;
      acc = '0;
      for (int unsigned i = 0; i < MAX_DATA_W / LANE_W; i++) begin
         if (i < lanes) begin
            acc = acc ^ d[i*LANE_W +: LANE_W];
         end
      end
      return acc;
   endfunction

   // Rotate a 64-bit signature left by one bit.
   function automatic logic [LANE_W-1:0] rotl1(input logic [LANE_W-1:0] x);
      return {x[LANE_W-2:0], x[LANE_W-1]};
   endfunction

endpackage : sink_pkg
`default_nettype wire

// File: rtl/stream_sink_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : stream_sink_lfsr
// Description : 16-bit Fibonacci LFSR used to throttle the sink read strobe.
//               Loads SEED on reset and on load; steps when advance is high.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_sink_lfsr
   import sink_pkg::*;
#(
   parameter logic [15:0] SEED = SINK_LFSR_SEED,
   parameter logic [15:0] TAPS = SINK_LFSR_TAPS
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        advance,
   output logic [15:0] lfsr
);

   logic [15:0] lfsr_q;
   logic [15:0] lfsr_d;

   // Next value: reseed on load, otherwise shift in the tap parity.
   always_comb begin
      lfsr_d = lfsr_q;
      if (load) begin
         lfsr_d = SEED;
      end else if (advance) begin
         lfsr_d = {lfsr_q[14:0], ^(lfsr_q & TAPS)};
      end
   end

   // LFSR state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lfsr_q <= SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign lfsr = lfsr_q;

endmodule : stream_sink_lfsr
`default_nettype wire

// File: rtl/stream_sink_checker.sv
`default_nettype none
// ============================================================================
// Module      : stream_sink_checker
// Description : Drains a programmed number of beats from an ap_fifo style
//               source, counts beats and stalls, folds the data into a 64-bit
//               signature and reports done or watchdog timeout.
//               Optional read throttling: define SINK_BACKPRESSURE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_sink_checker
   import sink_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 512,
   parameter int unsigned CNT_WIDTH     = 32,
   parameter int unsigned TIMEOUT_WIDTH = 24,
   parameter logic [15:0] LFSR_SEED     = SINK_LFSR_SEED
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [CNT_WIDTH-1:0]  expected_beats,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  empty_n,
   output logic                  read,
   output logic [CNT_WIDTH-1:0]  beat_cnt,
   output logic [CNT_WIDTH-1:0]  stall_cnt,
   output logic [63:0]           checksum,
   output logic                  busy,
   output logic                  done,
   output logic                  timeout
);

   localparam int unsigned              LANES    = DATA_WIDTH / LANE_W;
   localparam logic [CNT_WIDTH-1:0]     CNT_ONE  = 1;
   localparam logic [TIMEOUT_WIDTH-1:0] IDLE_ONE = 1;

   state_e                   state_q,     state_d;
   logic [CNT_WIDTH-1:0]     beat_cnt_q,  beat_cnt_d;
   logic [CNT_WIDTH-1:0]     stall_cnt_q, stall_cnt_d;
   logic [CNT_WIDTH-1:0]     target_q,    target_d;
   logic [63:0]              checksum_q,  checksum_d;
   logic [TIMEOUT_WIDTH-1:0] idle_cnt_q,  idle_cnt_d;

   logic                  w_throttle_ok;
   logic                  w_arm;
   logic [MAX_DATA_W-1:0] w_din_ext;

   // A start pulse is honoured in every state except RUN.
   assign w_arm     = start && (state_q != RUN);
   assign w_din_ext = {{(MAX_DATA_W - DATA_WIDTH){1'b0}}, din};

`ifdef SINK_BACKPRESSURE_EN
   logic [15:0] w_lfsr;

   stream_sink_lfsr #(
      .SEED (LFSR_SEED),
      .TAPS (SINK_LFSR_TAPS)
   ) u_lfsr (
      .clk     (clk),
      .reset   (reset),
      .load    (w_arm),
      .advance (state_q == RUN),
      .lfsr    (w_lfsr)
   );

   assign w_throttle_ok = w_lfsr[0] | w_lfsr[1];
`else
   logic [15:0] unused_seed;
   assign unused_seed   = LFSR_SEED;
   assign w_throttle_ok = 1'b1;
`endif

   // Next-state, counter and read-strobe logic; read depends only on
   // registered state, empty_n and the throttle, never on din.
   always_comb begin
      state_d     = state_q;
      beat_cnt_d  = beat_cnt_q;
      stall_cnt_d = stall_cnt_q;
      target_d    = target_q;
      checksum_d  = checksum_q;
      idle_cnt_d  = idle_cnt_q;
      read        = 1'b0;

      case (state_q)
         RUN: begin
            read = empty_n && (beat_cnt_q != target_q) && w_throttle_ok;
            if (!empty_n && (stall_cnt_q != '1)) begin
               stall_cnt_d = stall_cnt_q + CNT_ONE;
            end
            // Completion is checked before the watchdog so a run that just
            // took its final beat always ends in DONE.
            if (beat_cnt_q == target_q) begin
               state_d = DONE;
            end else if (read) begin
               beat_cnt_d = beat_cnt_q + CNT_ONE;
               checksum_d = rotl1(checksum_q) ^ fold64(w_din_ext, LANES);
               idle_cnt_d = '0;
            end else begin
               idle_cnt_d = idle_cnt_q + IDLE_ONE;
               if (idle_cnt_d == '1) begin
                  state_d = TOUT;
               end
            end
         end
         default: begin
            if (start) begin
               state_d     = RUN;
               beat_cnt_d  = '0;
               stall_cnt_d = '0;
               checksum_d  = '0;
               idle_cnt_d  = '0;
               target_d    = expected_beats;
            end
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         beat_cnt_q  <= '0;
         stall_cnt_q <= '0;
         target_q    <= '0;
         checksum_q  <= '0;
         idle_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         beat_cnt_q  <= beat_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         target_q    <= target_d;
         checksum_q  <= checksum_d;
         idle_cnt_q  <= idle_cnt_d;
      end
   end

   assign beat_cnt  = beat_cnt_q;
   assign stall_cnt = stall_cnt_q;
   assign checksum  = checksum_q;
   assign busy      = (state_q == RUN);
   assign done      = (state_q == DONE);
   assign timeout   = (state_q == TOUT);

endmodule : stream_sink_checker
`default_nettype wire

// File: tb/tb_stream_sink_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_sink_checker
// Description : Randomized self-checking bench for stream_sink_checker with a
//               transaction-level reference model (accepted-beat queue,
//               stall tally, idle-gap watchdog).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_sink_checker;

   localparam int DW = 512;
   localparam int CW = 32;
   localparam int TW = 4;
   localparam int IDLE_LIMIT = (1 << TW) - 1;
   localparam int CYCLE_BUDGET = 400;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [CW-1:0] expected_beats;
   logic [DW-1:0] din;
   logic          empty_n;
   logic          read;
   logic [CW-1:0] beat_cnt;
   logic [CW-1:0] stall_cnt;
   logic [63:0]   checksum;
   logic          busy;
   logic          done;
   logic          timeout;

   int n_tests = 0;
   int n_fail  = 0;

   // Bench-side copy of the throttle sequence (only consulted with the feature on).
   logic [15:0] lf = 16'hACE1;

   stream_sink_checker #(
      .DATA_WIDTH    (DW),
      .CNT_WIDTH     (CW),
      .TIMEOUT_WIDTH (TW),
      .LFSR_SEED     (16'hACE1)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .expected_beats (expected_beats),
      .din            (din),
      .empty_n        (empty_n),
      .read           (read),
      .beat_cnt       (beat_cnt),
      .stall_cnt      (stall_cnt),
      .checksum       (checksum),
      .busy           (busy),
      .done           (done),
      .timeout        (timeout)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] fold_ref(input logic [DW-1:0] d);
      logic [63:0] acc = '0;
      for (int i = 0; i < DW / 64; i++) acc = acc ^ d[i*64 +: 64];
      return acc;
   endfunction

   function automatic logic [63:0] rotl_ref(input logic [63:0] x);
      return (x << 1) | (x >> 63);
   endfunction

   function automatic logic [DW-1:0] rand_data();
      logic [DW-1:0] d;
      for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   function automatic bit throttle_now();
      bit t = lf[0] | lf[1];
`ifndef SINK_BACKPRESSURE_EN
      t = 1'b1;
`endif
      return t;
   endfunction

   // One run: start, feed beats in the chosen empty_n pattern, then check
   // the final result against the queue-based model.
   // mode 0: always valid, 1: valid every third cycle, 2: random ~70%,
   // 3: one valid cycle then empty forever.
   task automatic run_case(input string tag, input int target, input int mode);
      logic [DW-1:0] q[$];
      logic [63:0]   sum = '0;
      int  stalls = 0;
      int  gap = 0;
      int  cyc = 0;
      bit  fin = 0;
      bit  tmo = 0;
      bit  e;
      bit  rd;
      @(negedge clk);
      start = 1'b1; expected_beats = CW'(target); empty_n = 1'b0; din = '0;
      @(negedge clk);
      start = 1'b0;
      lf = 16'hACE1;
      while (!fin && !tmo && cyc < CYCLE_BUDGET) begin
         check_val({tag, "_state"}, {61'd0, busy, done, timeout}, 64'd4);
         case (mode)
            0:       e = 1'b1;
            1:       e = (cyc % 3) == 0;
            2:       e = ($urandom_range(0, 9) < 7);
            default: e = (cyc == 0);
         endcase
         empty_n = e;
         din     = rand_data();
         rd      = e && (q.size() < target) && throttle_now();
         #1;
         check_val({tag, "_read"}, {63'd0, read}, {63'd0, rd});
         if (q.size() == target) begin
            if (!e) stalls++;
            fin = 1'b1;
         end else if (rd) begin
            q.push_back(din);
            gap = 0;
         end else begin
            if (!e) stalls++;
            gap++;
            if (gap == IDLE_LIMIT) tmo = 1'b1;
         end
         lf = {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
         cyc++;
         @(negedge clk);
      end
      if (cyc >= CYCLE_BUDGET) check_val({tag, "_budget"}, 64'd0, 64'd1);
      foreach (q[i]) sum = rotl_ref(sum) ^ fold_ref(q[i]);
      check_val({tag, "_flags"}, {61'd0, busy, done, timeout}, {61'd0, 1'b0, fin, tmo});
      check_val({tag, "_beats"}, 64'(beat_cnt), 64'(q.size()));
      check_val({tag, "_stalls"}, 64'(stall_cnt), 64'(stalls));
      check_val({tag, "_checksum"}, checksum, sum);
      // Results must hold and no read may issue after the run ends.
      empty_n = 1'b1;
      #1;
      check_val({tag, "_hold_read"}, {63'd0, read}, 64'd0);
      @(negedge clk);
      check_val({tag, "_hold_beats"}, 64'(beat_cnt), 64'(q.size()));
      empty_n = 1'b0;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; expected_beats = '0; din = '0; empty_n = 1'b0;
      repeat (2) @(negedge clk);
      check_val("reset_flags", {60'd0, busy, done, timeout, read}, 64'd0);
      check_val("reset_counts", {beat_cnt, stall_cnt}, 64'd0);
      check_val("reset_checksum", checksum, 64'd0);
      reset = 1'b0;

      run_case("four", 4, 0);
      run_case("zero", 0, 0);
      run_case("toggle8", 8, 1);
      run_case("tmo", 3, 3);

      // Asynchronous reset part-way through a run.
      @(negedge clk);
      start = 1'b1; expected_beats = 6; empty_n = 1'b1; din = rand_data();
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
`ifndef SINK_BACKPRESSURE_EN
      check_val("midrun_beats", 64'(beat_cnt), 64'd2);
`endif
      #1 reset = 1'b1;
      #1;
      check_val("midrun_flags", {60'd0, busy, done, timeout, read}, 64'd0);
      check_val("midrun_counts", {beat_cnt, stall_cnt}, 64'd0);
      check_val("midrun_checksum", checksum, 64'd0);
      @(negedge clk);
      reset = 1'b0; empty_n = 1'b0;
      run_case("rerun", 2, 0);

      for (int k = 0; k < 6; k++) begin
         run_case($sformatf("rand%0d", k), int'($urandom_range(1, 20)), 2);
      end
`ifdef SINK_BACKPRESSURE_EN
      run_case("throttle100", 100, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_stream_sink_checker
`default_nettype wire
